// File: rtl/subgraph_pack_buffer.sv
// subgraph_pack_buffer: packs per-neighbour scalars into one MAX_NODES-lane word plus count,
// queued in a 2-entry output FIFO. Optional macro PACK_ZERO_FILL_EN zeroes unused lanes.
module subgraph_pack_buffer #(
    parameter int DATA_W     = 8,
    parameter int MAX_NODES  = 16,
    parameter int NODE_CNT_W = $clog2(MAX_NODES + 1),
    parameter int PACK_W     = MAX_NODES * DATA_W + NODE_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    input  logic [NODE_CNT_W-1:0] in_num_nodes_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [PACK_W-1:0]     out_data_o,
    output logic                  err_num_nodes_o
);
    // state | meaning
    // IDLE  | waiting for the first beat of a group (lane 1)
    // FILL  | writing lanes 2..n of the current group
    typedef enum logic {IDLE, FILL} state_t;

    localparam int LANES_W = MAX_NODES * DATA_W;
    localparam logic [NODE_CNT_W-1:0] CNT_ONE = NODE_CNT_W'(1);
    localparam logic [NODE_CNT_W-1:0] CNT_MAX = NODE_CNT_W'(MAX_NODES);

    state_t                state_q, state_d;
    logic [NODE_CNT_W-1:0] lane_idx_q, lane_idx_d;
    logic [NODE_CNT_W-1:0] num_q, num_d;
    logic [LANES_W-1:0]    asm_q, asm_d;
    logic                  err_q, err_d;
    logic [PACK_W-1:0]     fifo_q [2];
    logic [PACK_W-1:0]     fifo_wdata;
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q, count_d;
    logic                  accept, push, pop, num_bad;
    logic [NODE_CNT_W-1:0] num_fix, cur_idx, cur_num;

    assign in_ready_o      = (count_q != 2'd2);
    assign accept          = in_valid_i && in_ready_o;
    assign out_valid_o     = (count_q != 2'd0);
    assign pop             = out_valid_o && out_ready_i;
    assign out_data_o      = out_valid_o ? fifo_q[rd_ptr_q] : '0;
    assign err_num_nodes_o = err_q;

    always_comb begin
        num_fix = in_num_nodes_i;
        num_bad = 1'b0;
        if (in_num_nodes_i == '0) begin
            num_fix = CNT_ONE;
            num_bad = 1'b1;
        end else if (in_num_nodes_i > CNT_MAX) begin
            num_fix = CNT_MAX;
            num_bad = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        num_d      = num_q;
        asm_d      = asm_q;
        err_d      = err_q;
        push       = 1'b0;
        cur_idx    = (state_q == IDLE) ? CNT_ONE : lane_idx_q;
        cur_num    = (state_q == IDLE) ? num_fix : num_q;
        if (accept) begin
            if (state_q == IDLE) begin
                num_d = num_fix;
                err_d = err_q | num_bad;
`ifdef PACK_ZERO_FILL_EN
                asm_d = '0;
`endif
            end
            for (int i = 0; i < MAX_NODES; i++) begin
                if (cur_idx == NODE_CNT_W'(i + 1))
                    asm_d[LANES_W-1-i*DATA_W -: DATA_W] = in_data_i;
            end
            if (cur_idx == cur_num) begin
                push       = 1'b1;
                state_d    = IDLE;
                lane_idx_d = CNT_ONE;
            end else begin
                state_d    = FILL;
                lane_idx_d = cur_idx + CNT_ONE;
            end
        end
        // The pushed word includes the lane written this very cycle.
        fifo_wdata = {asm_d, cur_num};
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lane_idx_q <= CNT_ONE;
            num_q      <= '0;
            asm_q      <= '0;
            err_q      <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
        end else begin
            lane_idx_q <= lane_idx_d;
            num_q      <= num_d;
            asm_q      <= asm_d;
            err_q      <= err_d;
            count_q    <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= fifo_wdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end
endmodule
